issueq_free_list: RTL and testbench

- Owns and updates the issue-queue free-entry bit vector.
- Each cycle, dispatch takes up to ALLOC_WIDTH free entry indices from it.
- Each cycle, issue/grant logic returns up to FREE_WIDTH entry indices to it. Each returned index is decoded to a one-hot mask and ORed back into the vector.
- Sits between dispatch and the issue queue payload RAM; provides the allocation indices dispatch writes into.

---
 rtl/issueq_free_list.sv | 125 ++++++++++++
 tb/tb_issueq_free_list.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issueq_free_list.sv
// Issue-queue free-entry vector: picks dispatch indices, merges freed ones.
// Define ISSUEQ_FREELIST_CHECK_EN to add the sticky freeListError_o port.
module issueq_free_list #(
  parameter int SIZE_ISSUEQ     = 32,
  parameter int SIZE_ISSUEQ_LOG = 5,
  parameter int ALLOC_WIDTH     = 4,
  parameter int FREE_WIDTH      = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   flush_i,
  input  logic [ALLOC_WIDTH-1:0]                 allocReq_i,
  output logic                                   allocReady_o,
  output logic [ALLOC_WIDTH-1:0]                 allocValid_o,
  output logic [ALLOC_WIDTH*SIZE_ISSUEQ_LOG-1:0] allocIdx_o,
  input  logic [FREE_WIDTH-1:0]                  freeValid_i,
  input  logic [FREE_WIDTH*SIZE_ISSUEQ_LOG-1:0]  freeIdx_i,
`ifdef ISSUEQ_FREELIST_CHECK_EN
  output logic                                   freeListError_o,
`endif
  output logic [SIZE_ISSUEQ_LOG:0]               freeCount_o,
  output logic [SIZE_ISSUEQ-1:0]                 freeVector_o
);

  localparam int LW = SIZE_ISSUEQ_LOG;

  logic [SIZE_ISSUEQ-1:0] freeVector;
  logic [LW:0]            freeCount;
  logic [SIZE_ISSUEQ-1:0] remain;
  logic [SIZE_ISSUEQ-1:0] allocMask;
  logic [SIZE_ISSUEQ-1:0] freeMask;
  logic [SIZE_ISSUEQ-1:0] vecNext;
  logic [LW:0]            cntNext;
  logic [LW-1:0]          laneIdx [ALLOC_WIDTH];
  logic [LW-1:0]          fIdx    [FREE_WIDTH];
  logic [FREE_WIDTH-1:0]  fInRange;
  logic                   fire;

  assign allocReady_o = freeCount >= (LW+1)'(ALLOC_WIDTH);
  assign fire         = allocReady_o & (|allocReq_i);
  assign freeCount_o  = freeCount;
  assign freeVector_o = freeVector;

  // Each lane takes the lowest bit left after earlier lanes claimed theirs.
  always_comb begin
    remain       = freeVector;
    allocValid_o = '0;
    allocIdx_o   = '0;
    for (int k = 0; k < ALLOC_WIDTH; k++) begin
      laneIdx[k] = '0;
      for (int i = SIZE_ISSUEQ - 1; i >= 0; i--) begin
        if (remain[i]) begin
          laneIdx[k]      = LW'(i);
          allocValid_o[k] = 1'b1;
        end
      end
      if (allocValid_o[k]) remain[laneIdx[k]] = 1'b0;
      allocIdx_o[k*LW +: LW] = laneIdx[k];
    end
  end

  always_comb begin
    allocMask = '0;
    for (int k = 0; k < ALLOC_WIDTH; k++) begin
      if (fire && allocReq_i[k] && allocValid_o[k])
        allocMask[laneIdx[k]] = 1'b1;
    end
  end

  always_comb begin
    freeMask = '0;
    for (int j = 0; j < FREE_WIDTH; j++) begin
      fIdx[j]     = freeIdx_i[j*LW +: LW];
      fInRange[j] = {1'b0, fIdx[j]} < (LW+1)'(SIZE_ISSUEQ);
      if (freeValid_i[j] && fInRange[j])
        freeMask[fIdx[j]] = 1'b1;
    end
  end

  always_comb begin
    if (flush_i) vecNext = '1;
    else         vecNext = (freeVector & ~allocMask) | freeMask;
  end

  always_comb begin
    cntNext = '0;
    for (int i = 0; i < SIZE_ISSUEQ; i++)
      cntNext = cntNext + {{LW{1'b0}}, vecNext[i]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      freeVector <= '1;
      freeCount  <= (LW+1)'(SIZE_ISSUEQ);
    end else begin
      freeVector <= vecNext;
      freeCount  <= cntNext;
    end
  end

`ifdef ISSUEQ_FREELIST_CHECK_EN
  logic errNow;
  logic errSticky;

  always_comb begin
    errNow = 1'b0;
    for (int j = 0; j < FREE_WIDTH; j++) begin
      if (freeValid_i[j] && fInRange[j]) begin
        if (freeVector[fIdx[j]]) errNow = 1'b1;
        for (int m = j + 1; m < FREE_WIDTH; m++) begin
          if (freeValid_i[m] && fIdx[m] == fIdx[j]) errNow = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) errSticky <= 1'b0;
    else if (errNow) errSticky <= 1'b1;
  end

  assign freeListError_o = errSticky;
`endif

endmodule

// File: tb/tb_issueq_free_list.sv
// Directed self-checking bench for issueq_free_list.
// Build with ISSUEQ_FREELIST_CHECK_EN to also cover the error flag.
module tb_issueq_free_list;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_i;
  logic [3:0]  allocReq_i;
  logic        allocReady_o;
  logic [3:0]  allocValid_o;
  logic [19:0] allocIdx_o;
  logic [3:0]  freeValid_i;
  logic [19:0] freeIdx_i;
  logic [5:0]  freeCount_o;
  logic [31:0] freeVector_o;
`ifdef ISSUEQ_FREELIST_CHECK_EN
  logic        freeListError_o;
`endif

  int passCnt = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  issueq_free_list dut (
    .clk(clk),
    .reset(reset),
    .flush_i(flush_i),
    .allocReq_i(allocReq_i),
    .allocReady_o(allocReady_o),
    .allocValid_o(allocValid_o),
    .allocIdx_o(allocIdx_o),
    .freeValid_i(freeValid_i),
    .freeIdx_i(freeIdx_i),
`ifdef ISSUEQ_FREELIST_CHECK_EN
    .freeListError_o(freeListError_o),
`endif
    .freeCount_o(freeCount_o),
    .freeVector_o(freeVector_o)
  );

  function automatic logic [19:0] pk(input int a, input int b,
                                     input int c, input int d);
    pk = {d[4:0], c[4:0], b[4:0], a[4:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; flush_i = 0; allocReq_i = 0;
    freeValid_i = 0; freeIdx_i = 0;
  endtask

  task automatic doReset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic allocCycles(input int n);
    allocReq_i = 4'b1111;
    repeat (n) tick();
    allocReq_i = 0;
  endtask

  task automatic test_reset();
    doReset();
    totalCnt++;
    if (freeCount_o !== 6'd32)
      $display("FAIL rst_count got %0d want 32", freeCount_o);
    else passCnt++;
    totalCnt++;
    if (freeVector_o !== 32'hFFFF_FFFF)
      $display("FAIL rst_vec got %h want ffffffff", freeVector_o);
    else passCnt++;
    totalCnt++;
    if (allocReady_o !== 1'b1)
      $display("FAIL rst_ready got %b want 1", allocReady_o);
    else passCnt++;
`ifdef ISSUEQ_FREELIST_CHECK_EN
    totalCnt++;
    if (freeListError_o !== 1'b0)
      $display("FAIL rst_err got %b want 0", freeListError_o);
    else passCnt++;
`endif
  endtask

  task automatic test_alloc_basic();
    allocReq_i = 4'b1111;
    #1;
    totalCnt++;
    if (allocIdx_o !== pk(0, 1, 2, 3))
      $display("FAIL basic_idx0 got %h want %h", allocIdx_o, pk(0, 1, 2, 3));
    else passCnt++;
    totalCnt++;
    if (allocValid_o !== 4'b1111)
      $display("FAIL basic_valid got %b want 1111", allocValid_o);
    else passCnt++;
    tick();
    allocReq_i = 0;
    totalCnt++;
    if (freeCount_o !== 6'd28)
      $display("FAIL basic_count got %0d want 28", freeCount_o);
    else passCnt++;
    totalCnt++;
    if (freeVector_o !== 32'hFFFF_FFF0)
      $display("FAIL basic_vec got %h want fffffff0", freeVector_o);
    else passCnt++;
    totalCnt++;
    if (allocIdx_o !== pk(4, 5, 6, 7))
      $display("FAIL basic_idx1 got %h want %h", allocIdx_o, pk(4, 5, 6, 7));
    else passCnt++;
  endtask

  task automatic test_full();
    doReset();
    allocCycles(8);
    totalCnt++;
    if (freeCount_o !== 6'd0 || allocReady_o !== 1'b0)
      $display("FAIL full_state got cnt=%0d rdy=%b want 0/0",
               freeCount_o, allocReady_o);
    else passCnt++;
    totalCnt++;
    if (allocValid_o !== 4'b0000 || allocIdx_o !== 20'd0)
      $display("FAIL full_lanes got v=%b idx=%h want 0/0",
               allocValid_o, allocIdx_o);
    else passCnt++;
    allocReq_i = 4'b1111;
    tick();
    allocReq_i = 0;
    totalCnt++;
    if (freeCount_o !== 6'd0 || freeVector_o !== 32'd0)
      $display("FAIL full_ignore got cnt=%0d vec=%h want 0/0",
               freeCount_o, freeVector_o);
    else passCnt++;
    freeValid_i = 4'b0011;
    freeIdx_i = pk(5, 17, 0, 0);
    allocReq_i = 4'b1111;
    tick();
    totalCnt++;
    if (freeCount_o !== 6'd2 || allocReady_o !== 1'b0)
      $display("FAIL full_free2 got cnt=%0d rdy=%b want 2/0",
               freeCount_o, allocReady_o);
    else passCnt++;
    allocReq_i = 0;
    freeValid_i = 4'b0111;
    freeIdx_i = pk(1, 2, 30, 0);
    tick();
    freeValid_i = 0;
    totalCnt++;
    if (freeCount_o !== 6'd5 || allocReady_o !== 1'b1)
      $display("FAIL full_free5 got cnt=%0d rdy=%b want 5/1",
               freeCount_o, allocReady_o);
    else passCnt++;
    totalCnt++;
    if (allocIdx_o !== pk(1, 2, 5, 17))
      $display("FAIL full_idx got %h want %h", allocIdx_o, pk(1, 2, 5, 17));
    else passCnt++;
    totalCnt++;
    if (freeVector_o !== 32'h4002_0026)
      $display("FAIL full_vec got %h want 40020026", freeVector_o);
    else passCnt++;
  endtask

  task automatic test_same_cycle();
    doReset();
    allocCycles(3);
    freeValid_i = 4'b0011;
    freeIdx_i = pk(0, 1, 0, 0);
    tick();
    totalCnt++;
    if (freeCount_o !== 6'd22 || freeVector_o !== 32'hFFFF_F003)
      $display("FAIL same_pre got cnt=%0d vec=%h want 22/fffff003",
               freeCount_o, freeVector_o);
    else passCnt++;
    allocReq_i = 4'b0011;
    freeValid_i = 4'b0001;
    freeIdx_i = pk(9, 0, 0, 0);
    #1;
    totalCnt++;
    if (allocIdx_o !== pk(0, 1, 12, 13))
      $display("FAIL same_offer got %h want %h", allocIdx_o, pk(0, 1, 12, 13));
    else passCnt++;
    tick();
    idle();
    totalCnt++;
    if (freeCount_o !== 6'd21 || freeVector_o !== 32'hFFFF_F200)
      $display("FAIL same_post got cnt=%0d vec=%h want 21/fffff200",
               freeCount_o, freeVector_o);
    else passCnt++;
    totalCnt++;
    if (allocIdx_o[4:0] !== 5'd9)
      $display("FAIL same_next got %0d want 9", allocIdx_o[4:0]);
    else passCnt++;
  endtask

  task automatic test_flush();
    flush_i = 1;
    allocReq_i = 4'b1111;
    freeValid_i = 4'b0001;
    freeIdx_i = pk(10, 0, 0, 0);
    tick();
    idle();
    totalCnt++;
    if (freeVector_o !== 32'hFFFF_FFFF || freeCount_o !== 6'd32)
      $display("FAIL flush got vec=%h cnt=%0d want ffffffff/32",
               freeVector_o, freeCount_o);
    else passCnt++;
  endtask

  task automatic test_dup_free();
    allocCycles(4);
    freeValid_i = 4'b0011;
    freeIdx_i = pk(12, 12, 0, 0);
    tick();
    idle();
    totalCnt++;
    if (freeCount_o !== 6'd17 || freeVector_o !== 32'hFFFF_1000)
      $display("FAIL dup got cnt=%0d vec=%h want 17/ffff1000",
               freeCount_o, freeVector_o);
    else passCnt++;
`ifdef ISSUEQ_FREELIST_CHECK_EN
    totalCnt++;
    if (freeListError_o !== 1'b1)
      $display("FAIL dup_err got %b want 1", freeListError_o);
    else passCnt++;
    flush_i = 1;
    tick();
    idle();
    tick();
    totalCnt++;
    if (freeListError_o !== 1'b1)
      $display("FAIL dup_sticky got %b want 1", freeListError_o);
    else passCnt++;
`endif
  endtask

  task automatic test_reset_mid();
    doReset();
    allocCycles(5);
    allocReq_i = 4'b0011;
    tick();
    allocReq_i = 0;
    totalCnt++;
    if (freeCount_o !== 6'd10)
      $display("FAIL mid_pre got %0d want 10", freeCount_o);
    else passCnt++;
    reset = 1;
    flush_i = 1;
    allocReq_i = 4'b1111;
    tick();
    idle();
    totalCnt++;
    if (freeCount_o !== 6'd32 || allocReady_o !== 1'b1)
      $display("FAIL mid_rst got cnt=%0d rdy=%b want 32/1",
               freeCount_o, allocReady_o);
    else passCnt++;
    totalCnt++;
    if (allocIdx_o[4:0] !== 5'd0)
      $display("FAIL mid_idx got %0d want 0", allocIdx_o[4:0]);
    else passCnt++;
  endtask

  task automatic test_empty_free();
    freeValid_i = 4'b0001;
    freeIdx_i = pk(3, 0, 0, 0);
    tick();
    idle();
    totalCnt++;
    if (freeCount_o !== 6'd32 || freeVector_o !== 32'hFFFF_FFFF)
      $display("FAIL empty_free got cnt=%0d vec=%h want 32/ffffffff",
               freeCount_o, freeVector_o);
    else passCnt++;
`ifdef ISSUEQ_FREELIST_CHECK_EN
    totalCnt++;
    if (freeListError_o !== 1'b1)
      $display("FAIL empty_err got %b want 1", freeListError_o);
    else passCnt++;
`endif
  endtask

  initial begin
    idle();
    reset = 1;
    tick();
    test_reset();
    test_alloc_basic();
    test_full();
    test_same_cycle();
    test_flush();
    test_dup_free();
    test_reset_mid();
    test_empty_free();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
